// File: rtl/mem_bus_bridge_pkg.sv
// mem_bus_bridge shared definitions.
// FSM encodings and default parameters.
package mem_bus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
  localparam int          TIMEOUT_DEF  = 16;

  function automatic int ctr_w(input int t);
    return $clog2(t) + 1;
  endfunction

endpackage

// File: rtl/mem_bus_bridge_if.sv
// External memory bus: req/ack handshake.
// Master issues requests, slave acks them.
interface mem_bus_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack
  );

endinterface

// File: rtl/mem_bus_bridge_timeout_ctr.sv
// Clear/increment wait counter with
// terminal-count flag at TIMEOUT-1.
module bus_timeout_ctr
  import mem_bus_bridge_pkg::*;
#(
  parameter int  TIMEOUT = TIMEOUT_DEF,
  localparam int CW      = ctr_w(TIMEOUT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(TIMEOUT - 1));

  // clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_bridge.sv
// Bridges control-unit memory strobes onto
// a req/ack bus, stalling the FSM meanwhile.
module mem_bus_bridge
  import mem_bus_bridge_pkg::*;
#(
  parameter int          AW       = 32,
  parameter int          DW       = 32,
  parameter int          TIMEOUT  = TIMEOUT_DEF,
  parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEF)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          MemReq,
  input  logic          MemWrite,
  input  logic          IRWrite,
  input  logic [AW-1:0] Adr,
  input  logic [DW-1:0] WriteData,
  output logic [DW-1:0] ReadData,
  output logic          Stall,
  output logic          AlignErr,
  output logic          BusErr,
  output logic          FetchErr,
  mem_bus_bridge_if.master bus
);

  state_t state;
  logic   tc;
  logic   ctr_clr;
  logic   ctr_inc;

  // hold the FSM until DONE releases it
  assign Stall = MemReq & (state != DONE);

  assign ctr_clr = (state == IDLE);
  assign ctr_inc = (state == BUSY) & ~bus.bus_ack & ~tc;

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_ctr (
    .clk   (clk),
    .rst_n (Reset),
    .clr   (ctr_clr),
    .inc   (ctr_inc),
    .tc    (tc)
  );

  // access FSM with registered bus/status outputs
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      ReadData      <= '0;
      AlignErr      <= 1'b0;
      BusErr        <= 1'b0;
      FetchErr      <= 1'b0;
    end else begin
      AlignErr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (MemReq) begin
            if (Adr[1:0] == 2'b00) begin
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= MemWrite;
              bus.bus_addr  <= Adr;
              bus.bus_wdata <= WriteData;
              state         <= BUSY;
            end else begin
              AlignErr <= 1'b1;
              state    <= DONE;
            end
          end
        end
        BUSY: begin
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            if (!bus.bus_we) ReadData <= bus.bus_rdata;
            state <= DONE;
          end else if (tc) begin
            bus.bus_req <= 1'b0;
            BusErr      <= 1'b1;
            FetchErr    <= FetchErr | IRWrite;
            if (!bus.bus_we) ReadData <= ERR_DATA;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
